// File: rtl/lvds_tx_pkg.sv
// Shared types and constants for the LVDS transmit lane scheduler.
package lvds_tx_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SER_RST,
        IDLE,
        RUN
    } lvds_state_t;

    localparam int LANE_BITS = 7;

    // Lowest colour bit carried by lanes 0..2, and by the two-bit fields of lane 3.
    localparam int VESA_MAIN_LO   = 0;
    localparam int VESA_EXTRA_LO  = 6;
    localparam int JEIDA_MAIN_LO  = 2;
    localparam int JEIDA_EXTRA_LO = 0;

    localparam logic [LANE_BITS-1:0] BLANK_WORD = 7'b000_0000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lvds_lane_map.sv
// One channel: 24-bit RGB plus {de,vs,hs} packed into LANES 7-bit lane words.
module lvds_lane_map
    import lvds_tx_pkg::*;
#(
    parameter int LANES = 4,
    parameter int JEIDA = 0
) (
    input  logic [23:0]                pix,
    input  logic [2:0]                 ctrl,
    output logic [LANES*LANE_BITS-1:0] word
);

    // RGB666 carries colour MSBs, which is the JEIDA layout for lanes 0..2.
    localparam int MLO = (JEIDA != 0 || LANES == 3) ? JEIDA_MAIN_LO : VESA_MAIN_LO;
    localparam int XLO = (JEIDA != 0) ? JEIDA_EXTRA_LO : VESA_EXTRA_LO;

    logic [7:0] r, g, b;

    assign r = pix[23:16];
    assign g = pix[15:8];
    assign b = pix[7:0];

    assign word[6:0]   = {g[MLO], r[MLO +: 6]};
    assign word[13:7]  = {b[MLO +: 2], g[MLO+1 +: 5]};
    assign word[20:14] = {ctrl, b[MLO+2 +: 4]};

    generate
        if (LANES == 4) begin : g_l3
            assign word[27:21] = {1'b0, b[XLO +: 2], g[XLO +: 2], r[XLO +: 2]};
        end
    endgenerate

endmodule

// File: rtl/lvds_tx_lane_sched.sv
// Start-up sequencer, skid buffer and lane mapper feeding the 7:1 LVDS serializers.
module lvds_tx_lane_sched
    import lvds_tx_pkg::*;
#(
    parameter int CH       = 2,
    parameter int LANES    = 4,
    parameter int JEIDA    = 0,
    parameter int LOCK_CYC = 1024,
    parameter int SRST_CYC = 16,
    parameter int IDLE_CYC = 4096
) (
    input  logic                        sclk,
    input  logic                        reset_n,
    input  logic                        pll_lock,
    input  logic [CH*24-1:0]            pix_data,
    input  logic [CH*3-1:0]             pix_ctrl,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    output logic [CH*LANES*LANE_BITS-1:0] lane_word,
    output logic                        ser_reset,
    output logic                        link_up,
    output logic                        underflow
);

    localparam int W       = CH*LANES*LANE_BITS;
    localparam int BW      = CH*27;
    localparam int CNT_MAX = max3(LOCK_CYC, SRST_CYC, IDLE_CYC);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYC - 1);
    localparam logic [CW-1:0] SRST_LAST = CW'(SRST_CYC - 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYC - 1);
    localparam logic [CW-1:0] CNT_TOP   = CW'(CNT_MAX);

    logic [1:0]    lock_sync;
    logic          lock_s;
    lvds_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;

    logic [BW-1:0] buf_q [2];
    logic          rd_ptr, wr_ptr;
    logic [1:0]    count, count_n;
    logic          run_ok, push, pop;
    logic [BW-1:0] head;
    logic [W-1:0]  mapped;

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) lock_sync <= 2'b00;
        else          lock_sync <= {lock_sync[0], pll_lock};
    end
    assign lock_s = lock_sync[1];

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cnt_inc = (cnt == CNT_TOP) ? cnt : cnt + CW'(1);
        if (!lock_s) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
        end else begin
            case (state)
                WAIT_LOCK: if (cnt == LOCK_LAST) begin state_n = SER_RST; cnt_n = '0; end
                           else cnt_n = cnt_inc;
                SER_RST:   if (cnt == SRST_LAST) begin state_n = IDLE; cnt_n = '0; end
                           else cnt_n = cnt_inc;
                IDLE:      if (cnt == IDLE_LAST) begin state_n = RUN; cnt_n = '0; end
                           else cnt_n = cnt_inc;
                default:   cnt_n = cnt;
            endcase
        end
    end

    assign ser_reset = (state == WAIT_LOCK) || (state == SER_RST);
    assign link_up   = (state == RUN);

    // A lock drop seen in RUN blanks and flushes on the same edge the FSM leaves RUN.
    assign run_ok = (state == RUN) && lock_s;
    assign push   = run_ok && pix_valid && pix_ready;
    assign pop    = run_ok && (count != 2'd0);

    always_comb begin
        count_n = count;
        if (!run_ok)           count_n = 2'd0;
        else if (push && !pop) count_n = count + 2'd1;
        else if (pop && !push) count_n = count - 2'd1;
    end

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (!run_ok) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count_n;
        end
    end

    always_ff @(posedge sclk) begin
        if (push) buf_q[wr_ptr] <= {pix_ctrl, pix_data};
    end

    assign head = buf_q[rd_ptr];

    generate
        for (genvar c = 0; c < CH; c++) begin : g_ch
            lvds_lane_map #(.LANES(LANES), .JEIDA(JEIDA)) u_map (
                .pix  (head[c*24 +: 24]),
                .ctrl (head[CH*24 + c*3 +: 3]),
                .word (mapped[c*LANES*LANE_BITS +: LANES*LANE_BITS])
            );
        end
    endgenerate

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            lane_word <= {CH*LANES{BLANK_WORD}};
            underflow <= 1'b0;
            pix_ready <= 1'b0;
        end else begin
            lane_word <= pop ? mapped : {CH*LANES{BLANK_WORD}};
            underflow <= run_ok && (count == 2'd0);
            pix_ready <= (state_n == RUN) && (count_n != 2'd2);
        end
    end

endmodule

// File: tb/tb_lvds_tx_lane_sched.sv
// Randomised bench for lvds_tx_lane_sched: VESA and JEIDA instances against a lock-history model.
module tb_lvds_tx_lane_sched;

    localparam int CH = 2, LANES = 4, W = CH*LANES*7;
    localparam int LOCK = 1024, SRST = 16, IDLE = 4096;
    localparam int T_SER = LOCK + SRST;
    localparam int T_RUN = LOCK + SRST + IDLE;

    logic          sclk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pll_lock = 1'b0;
    logic [47:0]   pix_data = '0;
    logic [5:0]    pix_ctrl = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready, ser_reset, link_up, underflow;
    logic [W-1:0]  lane_word;
    logic          pix_ready_j, ser_reset_j, link_up_j, underflow_j;
    logic [W-1:0]  lane_word_j;

    int checks = 0;
    int errors = 0;

    always #5 sclk = ~sclk;

    lvds_tx_lane_sched #(.CH(CH), .LANES(LANES), .JEIDA(0), .LOCK_CYC(LOCK),
                         .SRST_CYC(SRST), .IDLE_CYC(IDLE)) dut (
        .sclk(sclk), .reset_n(reset_n), .pll_lock(pll_lock), .pix_data(pix_data),
        .pix_ctrl(pix_ctrl), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .lane_word(lane_word), .ser_reset(ser_reset), .link_up(link_up), .underflow(underflow));

    lvds_tx_lane_sched #(.CH(CH), .LANES(LANES), .JEIDA(1), .LOCK_CYC(LOCK),
                         .SRST_CYC(SRST), .IDLE_CYC(IDLE)) dut_j (
        .sclk(sclk), .reset_n(reset_n), .pll_lock(pll_lock), .pix_data(pix_data),
        .pix_ctrl(pix_ctrl), .pix_valid(pix_valid), .pix_ready(pix_ready_j),
        .lane_word(lane_word_j), .ser_reset(ser_reset_j), .link_up(link_up_j), .underflow(underflow_j));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [27:0] map_ch(input logic [23:0] p, input logic [2:0] c, input bit jeida);
        logic [7:0] r, g, b;
        logic [6:0] l0, l1, l2, l3;
        r = p[23:16]; g = p[15:8]; b = p[7:0];
        if (!jeida) begin
            l0 = {g[0], r[5], r[4], r[3], r[2], r[1], r[0]};
            l1 = {b[1], b[0], g[5], g[4], g[3], g[2], g[1]};
            l2 = {c, b[5], b[4], b[3], b[2]};
            l3 = {1'b0, b[7], b[6], g[7], g[6], r[7], r[6]};
        end else begin
            l0 = {g[2], r[7], r[6], r[5], r[4], r[3], r[2]};
            l1 = {b[3], b[2], g[7], g[6], g[5], g[4], g[3]};
            l2 = {c, b[7], b[6], b[5], b[4]};
            l3 = {1'b0, b[1], b[0], g[1], g[0], r[1], r[0]};
        end
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [W-1:0] map_beat(input logic [53:0] beat, input bit jeida);
        return {map_ch(beat[47:24], beat[53:51], jeida), map_ch(beat[23:0], beat[50:48], jeida)};
    endfunction

    // Model: link phase follows from how many consecutive edges the synchronised lock has been high.
    initial begin : model_p
        int h;
        bit s1, s2, ls, ok, acc;
        logic [53:0] q[$];
        logic [53:0] beat;
        logic [W-1:0] e_lw, e_lwj;
        logic e_uf, e_rdy;
        h = 0; s1 = 0; s2 = 0; e_lw = '0; e_lwj = '0; e_uf = 0; e_rdy = 0;
        forever begin
            @(posedge sclk);
            if (!reset_n) begin
                h = 0; s1 = 0; s2 = 0; q.delete();
                e_lw = '0; e_lwj = '0; e_uf = 0; e_rdy = 0;
            end else begin
                ls = s2; s2 = s1; s1 = pll_lock;
                ok  = (h >= T_RUN) && ls;
                acc = pix_valid && e_rdy;
                if (ok && q.size() > 0) begin
                    beat  = q.pop_front();
                    e_lw  = map_beat(beat, 1'b0);
                    e_lwj = map_beat(beat, 1'b1);
                    e_uf  = 1'b0;
                end else begin
                    e_lw = '0; e_lwj = '0; e_uf = ok;
                end
                if (!ok) q.delete();
                else if (acc) q.push_back({pix_ctrl, pix_data});
                h = ls ? ((h < T_RUN) ? h + 1 : h) : 0;
                e_rdy = (h >= T_RUN);
            end
            @(negedge sclk);
            chk("lane_word", lane_word, e_lw);
            chk("lane_word_jeida", lane_word_j, e_lwj);
            chk("ctrl {ser_reset,link_up,pix_ready,underflow}",
                {ser_reset, link_up, pix_ready, underflow},
                {h < T_SER, h >= T_RUN, e_rdy, e_uf});
            chk("ctrl_jeida", {ser_reset_j, link_up_j, pix_ready_j, underflow_j},
                {h < T_SER, h >= T_RUN, e_rdy, e_uf});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic rand_beat(input int pct);
        pix_valid = ($urandom_range(0, 99) < pct);
        pix_data  = 48'({$urandom, $urandom});
        pix_ctrl  = 6'($urandom);
    endtask

    initial begin : stim_p
        int n, acc, bad;
        cyc(3);
        chk("reset_lane_word", lane_word, '0);
        chk("reset_ctrl", {ser_reset, link_up, pix_ready, underflow}, 4'b1000);
        reset_n = 1'b1;
        cyc(2);

        // Lock glitch restarts the debounce.
        pll_lock = 1'b1; cyc(500);
        pll_lock = 1'b0; cyc(1);
        pll_lock = 1'b1;
        n = 0;
        while (ser_reset && n < 3000) begin cyc(1); n++; end
        chk("lock_rise_to_ser_release", n, T_SER + 2);
        n = 0;
        while (!link_up && n < 6000) begin cyc(1); n++; end
        chk("ser_release_to_link_up", n, IDLE);

        // Fixed pixel through both mappings.
        pix_data = {24'h123456, 24'hA53CF0}; pix_ctrl = {3'b010, 3'b101};
        pix_valid = 1'b1; cyc(1); pix_valid = 1'b0; cyc(1);
        chk("vesa_L0", lane_word[6:0],   7'b0100101);
        chk("vesa_L1", lane_word[13:7],  7'b0011110);
        chk("vesa_L2", lane_word[20:14], 7'b1011100);
        chk("vesa_L3", lane_word[27:21], 7'b0110010);
        chk("jeida_L0", lane_word_j[6:0],   7'b1101001);
        chk("jeida_L1", lane_word_j[13:7],  7'b0000111);
        chk("jeida_L2", lane_word_j[20:14], 7'b1011111);
        chk("jeida_L3", lane_word_j[27:21], 7'b0000001);

        // Odd/even pixels land on channel 0/1 in the same cycle.
        pix_data = {8'h22, 16'h0, 8'h11, 16'h0}; pix_ctrl = 6'b100100;
        pix_valid = 1'b1; cyc(1); pix_valid = 1'b0; cyc(1);
        chk("ch0_L0", lane_word[6:0],   7'b0010001);
        chk("ch1_L0", lane_word[34:28], 7'b0100010);

        // Random stream with gaps.
        acc = 0; n = 0;
        while (acc < 100 && n < 1000) begin
            rand_beat(60);
            if (pix_valid && pix_ready) acc++;
            cyc(1); n++;
        end
        pix_valid = 1'b0;
        chk("stream_beats_accepted", acc, 100);
        cyc(3);

        // Lock loss mid-burst.
        repeat (10) begin rand_beat(100); cyc(1); end
        pll_lock = 1'b0;
        n = 0;
        while (!ser_reset && n < 10) begin rand_beat(100); cyc(1); n++; end
        chk("lockloss_latency", n, 3);
        chk("lockloss_outputs", {link_up, pix_ready, underflow}, 3'b000);
        chk("lockloss_lane_word", lane_word, '0);
        repeat (5) begin rand_beat(80); cyc(1); end
        pll_lock = 1'b1;
        n = 0; bad = 0;
        while (!link_up && n < 6000) begin
            rand_beat(80);
            if (pix_ready) bad++;
            cyc(1); n++;
        end
        chk("relock_to_link_up", n, T_RUN + 2 + 5 - 5 + 0);
        chk("no_ready_during_relock", bad, 0);
        repeat (30) begin rand_beat(70); cyc(1); end

        // Asynchronous reset mid-RUN.
        rand_beat(100);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_lane_word", lane_word, '0);
        chk("async_reset_ctrl", {ser_reset, link_up, pix_ready, underflow}, 4'b1000);
        cyc(2);
        reset_n = 1'b1;
        n = 0; bad = 0;
        while (!link_up && n < 6000) begin
            rand_beat(90);
            if (pix_ready) bad++;
            cyc(1); n++;
        end
        chk("reset_to_link_up", n, T_RUN + 2);
        chk("no_ready_before_run", bad, 0);
        repeat (40) begin rand_beat(60); cyc(1); end
        pix_valid = 1'b0;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
